// File: rtl/whackamole_pkg.sv
// -----------------------------------------------------------------------------
// whackamole_pkg
// Shared types and constants for the whack-a-mole round controller.
//   state_e        : round controller FSM states
//   LFSR_*         : position LFSR width and feedback taps (8,6,5,4)
//   NUM_HOLES/...  : datapath widths shared with the display stage
//   lfsr_step      : one Fibonacci shift of the position LFSR
//   no_repeat_pos  : bumps a candidate hole that equals the previous hole
// -----------------------------------------------------------------------------
package whackamole_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam int unsigned LFSR_W = 8;
    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    localparam int unsigned NUM_HOLES = 8;
    localparam int unsigned POS_W     = 3;
    localparam int unsigned SCORE_W   = 8;
    localparam int unsigned MISS_W    = 4;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [POS_W-1:0] no_repeat_pos(
        input logic [POS_W-1:0] cand,
        input logic [POS_W-1:0] prev
    );
        if (cand != prev) begin
            return cand;
        end
        if (cand == POS_W'(NUM_HOLES - 1)) begin
            return '0;
        end
        return cand + POS_W'(1);
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// -----------------------------------------------------------------------------
// mole_lfsr
// Free-running 8-bit Fibonacci LFSR that proposes the next mole hole. The low
// three bits form the candidate; a candidate equal to the previous hole is
// moved to the next hole so the mole never appears twice in a row.
// Ports:
//   i_clk        : system clock
//   i_rst        : synchronous active-high reset (reloads SEED)
//   i_prev_pos   : hole used by the previous round
//   o_position   : proposed hole for the next spawn
// -----------------------------------------------------------------------------
module mole_lfsr
    import whackamole_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [POS_W-1:0] i_prev_pos,
    output logic [POS_W-1:0] o_position
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Steps every cycle regardless of the game state so the spawn position
    // depends on how long the player took.
    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_position = no_repeat_pos(lfsr_q[POS_W-1:0], i_prev_pos);

endmodule

// File: rtl/mole_round_controller.sv
// -----------------------------------------------------------------------------
// mole_round_controller
// Game-round engine for the whack-a-mole datapath: spawns the mole, times the
// reaction window, grades the guess, and keeps score and misses.
//
//   state | meaning
//   IDLE  | after reset, waiting for i_start
//   SPAWN | one cycle: latch new mole hole, load reaction timer
//   WAIT  | mole up, waiting for a guess or timer expiry
//   PAUSE | dead time after a graded round
//   OVER  | miss limit reached, waiting for i_start
//
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_start               : start / restart pulse (wins over everything else)
//   i_guess_valid, i_guess: debounced guess pulse and hole index
//   o_mole_position       : current mole hole
//   o_mole_active         : high in WAIT
//   o_user_guess          : last graded guess
//   o_user_right/wrong    : one-cycle grading pulses
//   o_score, o_misses     : saturating counters
//   o_game_over           : high in OVER
// -----------------------------------------------------------------------------
module mole_round_controller
    import whackamole_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned       PAUSE_CYCLES   = 25_000_000,
    parameter int unsigned       MAX_MISSES     = 3,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_guess_valid,
    input  logic [POS_W-1:0]   i_guess,
    output logic [POS_W-1:0]   o_mole_position,
    output logic               o_mole_active,
    output logic [POS_W-1:0]   o_user_guess,
    output logic               o_user_right,
    output logic               o_user_wrong,
    output logic [SCORE_W-1:0] o_score,
    output logic [MISS_W-1:0]  o_misses,
    output logic               o_game_over
);

    localparam int unsigned TIMER_MAX = (TIMEOUT_CYCLES > PAUSE_CYCLES) ?
                                        TIMEOUT_CYCLES : PAUSE_CYCLES;
    localparam int unsigned TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] WAIT_LOAD  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PAUSE_LOAD = TIMER_W'(PAUSE_CYCLES - 1);
    localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    // The mole hole register doubles as prev_pos for the no-repeat rule.
    logic [POS_W-1:0]   mole_pos_q, mole_pos_d;
    logic [POS_W-1:0]   guess_q, guess_d;
    logic               right_q, right_d;
    logic               wrong_q, wrong_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [MISS_W-1:0]  misses_q, misses_d;
    logic [POS_W-1:0]   lfsr_pos;

    logic [SCORE_W-1:0] score_inc;
    logic [MISS_W-1:0]  misses_inc;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_prev_pos (mole_pos_q),
        .o_position (lfsr_pos)
    );

    always_comb begin
        score_inc  = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);
        misses_inc = (misses_q == {MISS_W{1'b1}}) ? misses_q : misses_q + MISS_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        mole_pos_d = mole_pos_q;
        guess_d    = guess_q;
        right_d    = 1'b0;
        wrong_d    = 1'b0;
        score_d    = score_q;
        misses_d   = misses_q;

        unique case (state_q)
            ST_IDLE: begin
                // Only i_start leaves IDLE; handled by the override below.
            end
            ST_SPAWN: begin
                mole_pos_d = lfsr_pos;
                timer_d    = WAIT_LOAD;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_guess_valid) begin
                    // A guess on the last timer cycle still counts as a guess.
                    guess_d = i_guess;
                    if (i_guess == mole_pos_q) begin
                        right_d = 1'b1;
                        score_d = score_inc;
                    end else begin
                        wrong_d  = 1'b1;
                        misses_d = misses_inc;
                    end
                    timer_d = PAUSE_LOAD;
                    state_d = ST_PAUSE;
                end else if (timer_q == '0) begin
                    wrong_d  = 1'b1;
                    misses_d = misses_inc;
                    timer_d  = PAUSE_LOAD;
                    state_d  = ST_PAUSE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_PAUSE: begin
                if (timer_q == '0) begin
                    state_d = (misses_q >= MISS_LIMIT) ? ST_OVER : ST_SPAWN;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_OVER: begin
                // Counters hold until i_start.
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Start from any state clears the game and drops any grading that
        // would otherwise have been issued this cycle.
        if (i_start) begin
            state_d    = ST_SPAWN;
            timer_d    = timer_q;
            mole_pos_d = mole_pos_q;
            guess_d    = guess_q;
            right_d    = 1'b0;
            wrong_d    = 1'b0;
            score_d    = '0;
            misses_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            mole_pos_q <= '0;
            guess_q    <= '0;
            right_q    <= 1'b0;
            wrong_q    <= 1'b0;
            score_q    <= '0;
            misses_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            mole_pos_q <= mole_pos_d;
            guess_q    <= guess_d;
            right_q    <= right_d;
            wrong_q    <= wrong_d;
            score_q    <= score_d;
            misses_q   <= misses_d;
        end
    end

    assign o_mole_position = mole_pos_q;
    assign o_mole_active   = (state_q == ST_WAIT);
    assign o_user_guess    = guess_q;
    assign o_user_right    = right_q;
    assign o_user_wrong    = wrong_q;
    assign o_score         = score_q;
    assign o_misses        = misses_q;
    assign o_game_over     = (state_q == ST_OVER);

endmodule
